// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, base opcodes and the S1 pipeline bundle.
package enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fields held in S1; fmt stays raw so codes 6/7 survive to assembly.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        range_err;
    } s1_t;

endpackage

// File: rtl/enc_imm_range_check.sv
// Immediate representability check for each RV32I format.
// Purely combinational; undefined formats always report an error.
module enc_imm_range_check
    import enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        range_err
);

    logic sext_11;
    logic sext_12;
    logic sext_20;

    assign sext_11 = (imm[31:11] == '0) || (&imm[31:11]);
    assign sext_12 = (imm[31:12] == '0) || (&imm[31:12]);
    assign sext_20 = (imm[31:20] == '0) || (&imm[31:20]);

    // Select the sign-extension / alignment rule for the format.
    always_comb begin
        range_err = 1'b1;
        case (fmt)
            FMT_R:        range_err = 1'b0;
            FMT_I, FMT_S: range_err = !sext_11;
            FMT_B:        range_err = !sext_12 || imm[0];
            FMT_J:        range_err = !sext_20 || imm[0];
            FMT_U:        range_err = |imm[11:0];
            default:      range_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder: S1 latches fields and range flag,
// S2 holds the packed word behind a valid/ready output.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_range_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_err
);

    s1_t                  s1_q, s1_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic                 s2_err_q, s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        s1_adv;
    logic        s2_adv;
    logic        chk_err;
    logic [31:0] asm_instr;

    enc_imm_range_check u_chk (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .range_err (chk_err)
    );

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid     = s2_valid_q;
    assign out_instr     = s2_instr_q;
    assign out_range_err = s2_err_q;
    assign err_count     = err_cnt_q;

    // Scatter S1 fields into the instruction word for its format.
    always_comb begin
        asm_instr = NOP_INSTR;
        case (s1_q.fmt)
            FMT_R: asm_instr = {s1_q.funct7, s1_q.rs2, s1_q.rs1,
                                s1_q.funct3, s1_q.rd, s1_q.opcode};
            FMT_I: asm_instr = {s1_q.imm[11:0], s1_q.rs1,
                                s1_q.funct3, s1_q.rd, s1_q.opcode};
            FMT_S: asm_instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1,
                                s1_q.funct3, s1_q.imm[4:0], s1_q.opcode};
            FMT_B: asm_instr = {s1_q.imm[12], s1_q.imm[10:5],
                                s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            FMT_U: asm_instr = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            FMT_J: asm_instr = {s1_q.imm[20], s1_q.imm[10:1],
                                s1_q.imm[11], s1_q.imm[19:12],
                                s1_q.rd, s1_q.opcode};
            default: asm_instr = NOP_INSTR;
        endcase
    end

    // Pipeline advance and saturating error counter next state.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.fmt       = in_fmt;
                s1_d.opcode    = in_opcode;
                s1_d.rd        = in_rd;
                s1_d.rs1       = in_rs1;
                s1_d.rs2       = in_rs2;
                s1_d.funct3    = in_funct3;
                s1_d.funct7    = in_funct7;
                s1_d.imm       = in_imm;
                s1_d.range_err = chk_err;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = asm_instr;
                s2_err_d   = s1_q.range_err;
            end
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_err_q
                     && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, stall/reset
// sequences and a randomized stream against a reference model.
module tb_instr_encoder;
    import enc_pkg::*;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_instr2;
    logic        out_range_err;
    logic        out_range_err2;
    logic [7:0]  err_count;
    logic [1:0]  err_count2;
    logic        clr_err;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;
    exp_t exp_q[$];
    logic        hold_q = 1'b0;
    logic [31:0] prev_instr = '0;
    logic        prev_err = 1'b0;
    bit rand_done;

    instr_encoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_range_err(out_range_err),
        .err_count(err_count), .clr_err(clr_err)
    );

    instr_encoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_range_err(out_range_err2),
        .err_count(err_count2), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: value ranges and bit positions from the ISA.
    function automatic logic model_err(input logic [2:0] f,
                                       input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (f)
            3'd0: return 1'b0;
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3: return (s < -4096) || (s > 4095) || (s % 2 != 0);
            3'd4: return (imm % 4096) != 0;
            3'd5: return (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] fld(input logic [31:0] x,
                                        input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] model_instr(input vec_t v);
        logic [31:0] w;
        logic [31:0] m;
        m = v.imm;
        w = 32'(v.op) + (32'(v.f3) << 12);
        case (v.fmt)
            3'd0: w = w + (32'(v.rd) << 7) + (32'(v.rs1) << 15)
                      + (32'(v.rs2) << 20) + (32'(v.f7) << 25);
            3'd1: w = w + (32'(v.rd) << 7) + (32'(v.rs1) << 15)
                      + (fld(m, 11, 0) << 20);
            3'd2: w = w + (fld(m, 4, 0) << 7) + (32'(v.rs1) << 15)
                      + (32'(v.rs2) << 20) + (fld(m, 11, 5) << 25);
            3'd3: w = w + (fld(m, 11, 11) << 7) + (fld(m, 4, 1) << 8)
                      + (32'(v.rs1) << 15) + (32'(v.rs2) << 20)
                      + (fld(m, 10, 5) << 25) + (fld(m, 12, 12) << 31);
            3'd4: w = 32'(v.op) + (32'(v.rd) << 7)
                      + (fld(m, 31, 12) << 12);
            3'd5: w = 32'(v.op) + (32'(v.rd) << 7)
                      + (fld(m, 19, 12) << 12) + (fld(m, 11, 11) << 20)
                      + (fld(m, 10, 1) << 21) + (fld(m, 20, 20) << 31);
            default: w = 32'h13;
        endcase
        return w;
    endfunction

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] ei, input logic ee,
                                input int ec);
        vec_t v;
        v.fmt = f; v.op = op; v.rd = rd; v.rs1 = r1; v.rs2 = r2;
        v.f3 = f3; v.f7 = f7; v.imm = imm;
        v.exp_instr = ei; v.exp_err = ee; v.exp_cnt = ec;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic [31:0] r;
        v.fmt = 3'($urandom_range(0, 7));
        v.op = 7'($urandom); v.rd = 5'($urandom);
        v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        r = $urandom;
        case ($urandom_range(0, 3))
            0: v.imm = r;
            1: v.imm = 32'($signed($urandom_range(0, 8191)) - 4096);
            2: v.imm = {{11{r[20]}}, r[20:1], 1'b0};
            default: v.imm = r & 32'hFFFF_F000;
        endcase
        v.exp_instr = '0; v.exp_err = 1'b0; v.exp_cnt = 0;
        return v;
    endfunction

    task automatic send(input vec_t v);
        bit done;
        done = 0;
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct3 = v.f3;
        in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic wait_out(input string nm, input logic [31:0] ei,
                            input logic ee);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk({nm, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, "_instr"}, out_instr, ei);
            chk({nm, "_err"}, 32'(out_range_err), 32'(ee));
        end
    endtask

    // Scoreboard: order, hold stability and counter tracking.
    always @(negedge clk) begin
        exp_t e;
        bit xe;
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0; exp_cnt2 = 0; hold_q = 1'b0;
        end else begin
            xe = 0;
            chk("err_count", 32'(err_count), 32'(exp_cnt));
            chk("err_count_w2", 32'(err_count2), 32'(exp_cnt2));
            if (hold_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_instr", out_instr, prev_instr);
                chk("hold_err", 32'(out_range_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra: got %h expected none",
                             out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", out_instr, e.instr);
                    chk("sb_err", 32'(out_range_err), 32'(e.err));
                    xe = e.err;
                end
            end
            if (clr_err) begin
                exp_cnt = 0; exp_cnt2 = 0;
            end else if (xe) begin
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            if (in_valid && in_ready) begin
                vec_t v;
                v = mk(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                       in_funct3, in_funct7, in_imm, '0, 1'b0, 0);
                e.instr = model_instr(v);
                e.err = model_err(in_fmt, in_imm);
                exp_q.push_back(e);
                acc_cnt++;
            end
            hold_q = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_err = out_range_err;
        end
    end

    vec_t tbl[9];
    vec_t vi1, vs, vb, verr, stream[5];
    int acc0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        vi1 = mk(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,
                 32'h0010_0093, 1'b0, 0);
        vs = mk(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd4,
                32'hFE20_AE23, 1'b0, 0);
        vb = mk(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,
                32'h0020_8463, 1'b0, 0);
        verr = mk(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,
                  32'h0000_0093, 1'b1, 0);
        tbl[0] = vi1;
        tbl[1] = vs;
        tbl[2] = vb;
        tbl[3] = mk(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                    32'h1234_5000, 32'h1234_52B7, 1'b0, 0);
        tbl[4] = mk(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                    32'h8000_0093, 1'b1, 1);
        tbl[5] = mk(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,
                    32'h0020_8363, 1'b1, 2);
        tbl[6] = mk(3'd0, OP_REG, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000,
                    32'hDEAD_BEEF, 32'h4031_00B3, 1'b0, 2);
        tbl[7] = mk(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4,
                    32'hFFDF_F0EF, 1'b0, 2);
        tbl[8] = mk(3'd6, OP_IMM, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'd0,
                    32'h0000_0013, 1'b1, 3);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", 32'(out_range_err), 32'd0);
        chk("rst_cnt", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: accept at N, visible after N+1, transfer at N+2.
        send(vi1);
        @(negedge clk);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("lat_n2_instr", out_instr, 32'h0010_0093);
        @(posedge clk); #1;

        // Back-to-back pair lands on consecutive cycles.
        fork
            begin send(vs); send(vb); end
            begin
                wait_out("b2b_first", 32'hFE20_AE23, 1'b0);
                @(negedge clk);
                chk("b2b_second_valid", 32'(out_valid), 32'd1);
                chk("b2b_second_instr", out_instr, 32'h0020_8463);
            end
        join
        repeat (3) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;

        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out($sformatf("tbl%0d", i), tbl[i].exp_instr,
                     tbl[i].exp_err);
            @(negedge clk);
            chk($sformatf("tbl%0d_cnt", i), 32'(err_count),
                32'(tbl[i].exp_cnt));
            @(posedge clk); #1;
        end

        // Output stall: two accepts fill the pipe, then all drain.
        foreach (stream[i]) stream[i] = rand_vec();
        acc0 = acc_cnt;
        out_ready = 1'b0;
        fork
            begin foreach (stream[i]) send(stream[i]); end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
                @(posedge clk); #1 out_ready = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("drain%0d_valid", i),
                        32'(out_valid), 32'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;

        // Saturation on the narrow counter, then clear vs increment.
        for (int i = 0; i < 5; i++) send(verr);
        repeat (4) @(negedge clk);
        chk("sat_w2", 32'(err_count2), 32'd3);
        chk("sat_w8", 32'(err_count), 32'd5);
        @(posedge clk); #1;
        send(verr);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        chk("clr_prio_w8", 32'(err_count), 32'd0);
        chk("clr_prio_w2", 32'(err_count2), 32'd0);
        @(posedge clk); #1;

        // Randomized stream with random backpressure and clears.
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(rand_vec());
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    clr_err = ($urandom_range(0, 31) == 0);
                end
            end
        join
        out_ready = 1'b1; clr_err = 1'b0;
        repeat (6) @(negedge clk);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two words in flight.
        @(posedge clk); #1;
        send(verr);
        repeat (3) @(posedge clk); #1;
        send(vs); send(vb);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(err_count), 32'd0);
        chk("arst_cnt_w2", 32'(err_count2), 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send(vi1);
        wait_out("post_rst", 32'h0010_0093, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
